// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: access sizes, FSM states
// and the byte-lane mask helper.
package rv32i_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SPLIT = 2'b01,
        DONE  = 2'b10
    } lsu_state_t;

    // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next one.
    function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Lane alignment for the LSU: store mask and shifted store data for both
// words, plus extraction and sign/zero extension of load data.
module rv32i_lsu_align
    import rv32i_lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic [1:0]            st_off,
    input  logic [1:0]            st_size,
    input  logic [WORD_WIDTH-1:0] st_wdata,
    input  logic [1:0]            ld_off,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [WORD_WIDTH-1:0] ld_w0,
    input  logic [WORD_WIDTH-1:0] ld_w1,
    output logic [7:0]            mask,
    output logic [WORD_WIDTH-1:0] wdata_lo,
    output logic [WORD_WIDTH-1:0] wdata_hi,
    output logic [WORD_WIDTH-1:0] ld_data
);

    logic [4:0]            st_shift;
    logic [4:0]            ld_shift;
    logic [WORD_WIDTH-1:0] ld_word;
    logic                  ext_b;
    logic                  ext_h;

    assign st_shift = {st_off, 3'b000};
    assign ld_shift = {ld_off, 3'b000};

    assign mask     = byte_mask(st_size, st_off);
    assign wdata_lo = st_wdata << st_shift;
    assign wdata_hi = WORD_WIDTH'(({{WORD_WIDTH{1'b0}}, st_wdata} << st_shift) >> WORD_WIDTH);

    assign ld_word = WORD_WIDTH'({ld_w1, ld_w0} >> ld_shift);
    assign ext_b   = ~ld_unsigned & ld_word[7];
    assign ext_h   = ~ld_unsigned & ld_word[15];

    always_comb begin
        case (ld_size)
            SZ_B:    ld_data = {{(WORD_WIDTH-8){ext_b}}, ld_word[7:0]};
            SZ_H:    ld_data = {{(WORD_WIDTH-16){ext_h}}, ld_word[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit driving a one-cycle synchronous data TCM; accesses that
// cross a word boundary take a second TCM cycle.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [MASK_WIDTH-1:0] dtcm_wen,
    output logic [ADDR_WIDTH-1:0] dtcm_addr,
    output logic [WORD_WIDTH-1:0] dtcm_wdata,
    input  logic [WORD_WIDTH-1:0] dtcm_rdata
);

    lsu_state_t state;

    logic                  l_we;
    logic                  l_unsigned;
    logic                  l_split;
    logic                  l_err;
    logic [1:0]            l_size;
    logic [1:0]            l_off;
    logic [ADDR_WIDTH-3:0] l_word;
    logic [WORD_WIDTH-1:0] l_wdata;
    logic [WORD_WIDTH-1:0] w0_q;

    logic                  in_split;
    logic                  in_done;
    logic                  accept;
    logic                  is_split;
    logic                  fault;
    logic [ADDR_WIDTH-3:0] req_word;
    logic [ADDR_WIDTH-3:0] word_one;
    logic [ADDR_WIDTH-3:0] next_word;
    logic [1:0]            st_off;
    logic [1:0]            st_size;
    logic [WORD_WIDTH-1:0] st_wdata;
    logic [WORD_WIDTH-1:0] ld_w0;
    logic [7:0]            mask;
    logic [WORD_WIDTH-1:0] wdata_lo;
    logic [WORD_WIDTH-1:0] wdata_hi;
    logic [WORD_WIDTH-1:0] ld_data;

    assign in_split  = (state == SPLIT);
    assign in_done   = (state == DONE);
    assign req_ready = ~in_split;
    assign accept    = req_valid & req_ready;
    assign req_word  = req_addr[ADDR_WIDTH-1:2];
    assign word_one  = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
    assign next_word = l_word + word_one;

    // The store side of the aligner follows the live request, except during the
    // second half of a split where it replays the latched fields.
    assign st_off   = in_split ? l_off   : req_addr[1:0];
    assign st_size  = in_split ? l_size  : req_size;
    assign st_wdata = in_split ? l_wdata : req_wdata;
    assign ld_w0    = l_split  ? w0_q    : dtcm_rdata;

    assign is_split = |mask[2*MASK_WIDTH-1:MASK_WIDTH];
    assign fault    = (req_addr[31:ADDR_WIDTH] != '0) | (is_split & (&req_word));

    rv32i_lsu_align #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_align (
        .st_off      (st_off),
        .st_size     (st_size),
        .st_wdata    (st_wdata),
        .ld_off      (l_off),
        .ld_size     (l_size),
        .ld_unsigned (l_unsigned),
        .ld_w0       (ld_w0),
        .ld_w1       (dtcm_rdata),
        .mask        (mask),
        .wdata_lo    (wdata_lo),
        .wdata_hi    (wdata_hi),
        .ld_data     (ld_data)
    );

    always_comb begin
        dtcm_wen   = '0;
        dtcm_addr  = '0;
        dtcm_wdata = '0;
        if (in_split) begin
            dtcm_addr = {next_word, 2'b00};
            if (l_we) begin
                dtcm_wen   = mask[2*MASK_WIDTH-1:MASK_WIDTH];
                dtcm_wdata = wdata_hi;
            end
        end else if (accept && !fault) begin
            dtcm_addr = {req_word, 2'b00};
            if (req_we) begin
                dtcm_wen   = mask[MASK_WIDTH-1:0];
                dtcm_wdata = wdata_lo;
            end
        end
    end

    assign resp_valid = in_done;
    assign resp_err   = in_done & l_err;
    assign resp_rdata = (in_done && !l_err && !l_we) ? ld_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            l_we       <= 1'b0;
            l_unsigned <= 1'b0;
            l_split    <= 1'b0;
            l_err      <= 1'b0;
            l_size     <= '0;
            l_off      <= '0;
            l_word     <= '0;
            l_wdata    <= '0;
            w0_q       <= '0;
        end else begin
            case (state)
                SPLIT: begin
                    w0_q  <= dtcm_rdata;
                    state <= DONE;
                end
                default: begin
                    if (accept) begin
                        l_we       <= req_we;
                        l_unsigned <= req_unsigned;
                        l_size     <= req_size;
                        l_off      <= req_addr[1:0];
                        l_word     <= req_word;
                        l_wdata    <= req_wdata;
                        l_err      <= fault;
                        l_split    <= is_split & ~fault;
                        state      <= (fault || !is_split) ? DONE : SPLIT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the RV32I core. It takes byte, halfword and word load/store requests from the core's memory stage and drives the data TCM port: word address, 4-bit byte write-enable, and write data. The TCM has a one-cycle synchronous read. Misaligned accesses that cross a word boundary are split into two TCM accesses. Loads are extracted and sign- or zero-extended before the result is returned to the writeback path.

## Interface
Parameters:
- WORD_WIDTH, 32, data word width
- ADDR_WIDTH, 16, TCM byte-address width (64 KB)
- MASK_WIDTH, 4, byte-enable width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word (11 is treated as word)
- req_unsigned  in  1  zero-extend the load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse; no back-pressure
- resp_rdata  out  32  extended load data; 0 for stores, errors, or when resp_valid = 0
- resp_err  out  1  access fault, qualified by resp_valid
- dtcm_wen  out  4  byte write-enable to the TCM
- dtcm_addr  out  ADDR_WIDTH  byte address; the TCM uses bits [ADDR_WIDTH-1:2]
- dtcm_wdata  out  32  lane-aligned write data
- dtcm_rdata  in  32  TCM read data, valid the cycle after its address

## Operation
- Request fields: off = req_addr[1:0]; nbytes = 1, 2 or 4 from req_size. The access is a split access when off + nbytes > 4.
- Fault conditions: req_addr[31:ADDR_WIDTH] != 0, or a split access whose second word lies at or above 2^ADDR_WIDTH. On a fault, no TCM access is made (dtcm_wen = 0). resp_err = 1 and resp_rdata = 0 in the next cycle.
- Write mask: full = ((1 << nbytes) - 1) << off, computed 8 bits wide.
- First access: word address {addr[ADDR_WIDTH-1:2], 00}; dtcm_wen = full[3:0]; dtcm_wdata = req_wdata << 8*off.
- Second access: next word address; dtcm_wen = full[7:4]; dtcm_wdata = req_wdata >> 8*(4-off).
- Loads: dtcm_wen = 0. The load value is ({w1, w0} >> 8*off), truncated to nbytes and then sign- or zero-extended. For non-split accesses, w1 is don't-care.
- States:
  - IDLE: req_ready = 1. On accept, issue the first access combinationally from the req_* fields. A non-split access or a fault goes to DONE; a split access goes to SPLIT. Request fields are latched.
  - SPLIT: req_ready = 0. Capture w0 from dtcm_rdata. Issue the second access from the latched fields. Go to DONE.
  - DONE: resp_valid = 1. Loads form resp_rdata from dtcm_rdata (plus w0 if the access was split). req_ready = 1; a new accept follows the IDLE rules, otherwise go to IDLE.
- The TCM outputs are 0 (wen = 0) in any cycle with no access issued.

## Timing
- Non-split access: accept in cycle N, resp_valid in cycle N+1. Back-to-back throughput is one request per cycle.
- Split access: accept in cycle N, second access in N+1, resp_valid in N+2.
- Store data is written at the end of the issue cycle. A load issued in the next cycle to the same word returns the new data.
- Reset values: state = IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, dtcm_wen = 0, latched fields = 0. The core holds req_valid = 0 while rst_n = 0.
- Reset asserted mid-split: the remaining access and the response are dropped, and no partial second write occurs. A store whose first half was already written is not rolled back.
- resp_rdata and resp_err are held at 0 whenever resp_valid = 0.

## Structure
- Package rv32i_lsu_pkg holds: size encodings (SZ_B, SZ_H, SZ_W), the state enum (IDLE, SPLIT, DONE), and a byte-mask helper.
- One combinational sub-module, rv32i_lsu_align. It computes the mask, the shifted write data for both halves, and the load extraction and extension from off, size, unsigned, w0 and w1.
- The top module holds the FSM, the latches, and the fault check.

## Test plan
- SB 0xAB to 0x0102 (off 2): dtcm_wen = 0100, dtcm_wdata = 0x00AB0000, dtcm_addr = 0x0100. resp_valid = 1 the next cycle with resp_err = 0. A following LB from 0x0102 returns 0xFFFFFFAB; LBU returns 0x000000AB.
- SW 0x11223344 to 0x0203 (split): first access 0x0200 with wen 1000 and wdata 0x44000000; second access 0x0204 with wen 0111 and wdata 0x00112233. LW from 0x0203 returns 0x11223344 two cycles after accept.
- LH from 0x0013 with memory word 0x10 = 0x80xxxxxx and word 0x14 = 0xxxxxxx7F: resp_rdata = 0x00007F80. Signed and unsigned results match, since bit 15 is 0.
- Fault cases, each giving resp_err = 1, resp_rdata = 0 and no dtcm_wen pulse:
  - LW from 0x00010000
  - SW to 0x0000FFFE, a split whose second word is out of range
- Ten back-to-back aligned LWs: req_ready stays high and ten consecutive resp_valid pulses return the correct data.
- Assert rst_n low during SPLIT of a split SW: the second write never occurs, resp_valid stays 0, and the unit returns to IDLE with req_ready = 1 after release.
